// File: rtl/ifu_id_ex_pkg.sv
// ifu_id_ex_pkg -- shared constants and types for the rua RV32I fetch/decode/execute slice.
//   Opcode, funct3 and funct7 encodings, the ALU operation enum, the post-reset NOP
//   instruction and a helper that maps funct3 plus the alternate-function bit to an ALU op.
// Optional feature macro used by the importers: RUA_UPPER_IMM_EN (LUI/AUIPC support).
package ifu_id_ex_pkg;

  localparam logic [31:0] NOP_INST_C = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  // alt selects SUB for F3_ADD and SRA for F3_SR; it is ignored for the other funct3 codes.
  function automatic alu_op_e f3_alu_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ifu_id_ex_alu.sv
// ifu_id_ex_alu -- combinational RV32I integer ALU.
//   op_i     : operation select (alu_op_e)
//   a_i, b_i : signed operands; shifts use the low log2(XLEN) bits of b_i
//   result_o : result, wrapping modulo 2^XLEN; compares yield 1 or 0
module ifu_id_ex_alu
  import ifu_id_ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e                  op_i,
  input  logic signed [XLEN-1:0]   a_i,
  input  logic signed [XLEN-1:0]   b_i,
  output logic signed [XLEN-1:0]   result_o
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  logic            lt_s;
  logic            lt_u;

  assign shamt = b_i[SH_W-1:0];
  assign lt_s  = a_i < b_i;
  assign lt_u  = $unsigned(a_i) < $unsigned(b_i);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = $signed($unsigned(a_i) >> shamt);
      ALU_SRA:  result_o = a_i >>> shamt;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/ifu_id_ex.sv
// ifu_id_ex -- fetch/decode/execute datapath of the rua RV32I core.
//   Fetch : rom_addr = pc (combinational); inst registers rom_data every rising edge,
//           and loads NOP_INST on synchronous active-high rst.
//   Decode: register addresses straight from inst fields; R-type and I-type ALU ops.
//   Execute: ALU result driven on regs_out with regs_write_en; regs commits it at the
//           edge that fetches the next instruction, so no forwarding is needed.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pc / rom_addr / rom_data      fetch address in, ROM address out, ROM data in
//   inst                          registered current instruction
//   regs_addr1/2, regs_in1/2      rs1/rs2 addresses out, read data in
//   regs_write_addr/en, regs_out  rd, write enable and write-back data
// Configuration macro: RUA_UPPER_IMM_EN adds LUI/AUIPC and a pc register alongside inst.
module ifu_id_ex
  import ifu_id_ex_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          REG_AW   = 5,
  parameter logic [31:0] NOP_INST = NOP_INST_C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       inst,
  output logic [REG_AW-1:0] regs_addr1,
  output logic [REG_AW-1:0] regs_addr2,
  input  logic [XLEN-1:0]   regs_in1,
  input  logic [XLEN-1:0]   regs_in2,
  output logic [REG_AW-1:0] regs_write_addr,
  output logic              regs_write_en,
  output logic [XLEN-1:0]   regs_out
);

  logic [31:0] inst_q;
  logic [31:0] inst_d;

  assign rom_addr = pc;
  assign inst_d   = rom_data;

  // fetch stage -> decode/execute stage
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q <= NOP_INST;
    end else begin
      inst_q <= inst_d;
    end
  end

`ifdef RUA_UPPER_IMM_EN
  // AUIPC needs the address the current instruction was fetched from.
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  assign pc_d = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end
`endif

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign inst            = inst_q;
  assign opcode          = inst_q[6:0];
  assign funct3          = inst_q[14:12];
  assign funct7          = inst_q[31:25];
  assign regs_addr1      = inst_q[19:15];
  assign regs_addr2      = inst_q[24:20];
  assign regs_write_addr = inst_q[11:7];

  logic signed [XLEN-1:0] imm_i;
  logic signed [XLEN-1:0] op_a;
  logic signed [XLEN-1:0] op_b;
  logic signed [XLEN-1:0] alu_res;
  alu_op_e                alu_op;
  logic                   legal;

  assign imm_i = {{(XLEN-12){inst_q[31]}}, inst_q[31:20]};

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b0;
    op_a   = regs_in1;
    op_b   = regs_in2;
    case (opcode)
      OPC_OP: begin
        // Only ADD and SRL have an alternate (SUB/SRA) form; any other funct7 is illegal.
        legal  = (funct7 == F7_BASE) ||
                 ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
        alu_op = f3_alu_op(funct3, funct7[5]);
      end
      OPC_OP_IMM: begin
        op_b = imm_i;
        // Shift immediates carry funct7 in imm[11:5]; other I-types use the whole immediate,
        // so bit 30 must not turn ADDI into a subtract.
        if (funct3 == F3_SLL) begin
          legal = (funct7 == F7_BASE);
        end else if (funct3 == F3_SR) begin
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end else begin
          legal = 1'b1;
        end
        alu_op = f3_alu_op(funct3, (funct3 == F3_SR) && funct7[5]);
      end
`ifdef RUA_UPPER_IMM_EN
      OPC_LUI: begin
        legal = 1'b1;
        op_a  = '0;
        op_b  = XLEN'($signed({inst_q[31:12], 12'b0}));
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        op_a  = pc_q;
        op_b  = XLEN'($signed({inst_q[31:12], 12'b0}));
      end
`endif
      default: legal = 1'b0;
    endcase
  end

  ifu_id_ex_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .op_i     (alu_op),
    .a_i      (op_a),
    .b_i      (op_b),
    .result_o (alu_res)
  );

  // Writes to x0 are suppressed here so regs never sees a write it must discard.
  assign regs_write_en = legal && (regs_write_addr != '0);
  assign regs_out      = regs_write_en ? $unsigned(alu_res) : '0;

endmodule

// File: tb/tb_ifu_id_ex.sv
// tb_ifu_id_ex -- directed and randomized bench for ifu_id_ex.
//   A behavioural register file (xN = N after reset) surrounds the DUT; a separate
//   reference register array is advanced only from the bench's own instruction model.
//   Honours RUA_UPPER_IMM_EN the same way as the design.
module tb_ifu_id_ex;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] inst;
  logic [4:0]  regs_addr1;
  logic [4:0]  regs_addr2;
  logic [31:0] regs_in1;
  logic [31:0] regs_in2;
  logic [4:0]  regs_write_addr;
  logic        regs_write_en;
  logic [31:0] regs_out;

  int n_checks = 0;
  int n_pass   = 0;

  ifu_id_ex dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .inst            (inst),
    .regs_addr1      (regs_addr1),
    .regs_addr2      (regs_addr2),
    .regs_in1        (regs_in1),
    .regs_in2        (regs_in2),
    .regs_write_addr (regs_write_addr),
    .regs_write_en   (regs_write_en),
    .regs_out        (regs_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment register file, written by the DUT's write-back port.
  logic [31:0] env_regs [32];
  assign regs_in1 = env_regs[regs_addr1];
  assign regs_in2 = env_regs[regs_addr2];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) env_regs[i] <= 32'(i);
    end else if (regs_write_en && regs_write_addr != 5'd0) begin
      env_regs[regs_write_addr] <= regs_out;
    end
  end

  // Reference architectural state, advanced only by the model below.
  logic [31:0] mregs [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Architectural meaning of one instruction, from the RV32I rules.
  function automatic void ref_exec(input logic [31:0] w, input logic [31:0] ipc,
                                   output logic we, output logic [31:0] val);
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic        ok;
    logic        is_r;
    opc  = w[6:0];
    f7   = w[31:25];
    f3   = w[14:12];
    is_r = (opc == 7'h33);
    a    = mregs[w[19:15]];
    b    = is_r ? mregs[w[24:20]] : {{20{w[31]}}, w[31:20]};
    sh   = b[4:0];
    ok   = 1'b0;
    val  = 32'd0;
    if (is_r || opc == 7'h13) begin
      case (f3)
        3'd0: if (!is_r || f7 == 7'h00) begin ok = 1; val = a + b; end
              else if (f7 == 7'h20) begin ok = 1; val = a - b; end
        3'd1: if (f7 == 7'h00) begin ok = 1; val = a << sh; end
        3'd2: begin ok = (!is_r || f7 == 7'h00); val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        3'd3: begin ok = (!is_r || f7 == 7'h00); val = (a < b) ? 32'd1 : 32'd0; end
        3'd4: begin ok = (!is_r || f7 == 7'h00); val = a ^ b; end
        3'd5: if (f7 == 7'h00) begin ok = 1; val = a >> sh; end
              else if (f7 == 7'h20) begin ok = 1; val = $signed(a) >>> sh; end
        3'd6: begin ok = (!is_r || f7 == 7'h00); val = a | b; end
        default: begin ok = (!is_r || f7 == 7'h00); val = a & b; end
      endcase
    end
`ifdef RUA_UPPER_IMM_EN
    else if (opc == 7'h37) begin ok = 1; val = {w[31:12], 12'b0}; end
    else if (opc == 7'h17) begin ok = 1; val = {w[31:12], 12'b0} + ipc; end
`endif
    we = ok && (w[11:7] != 5'd0);
    if (!we) val = 32'd0;
  endfunction

  // Present one instruction, let it be fetched, then compare all decode/execute outputs.
  task automatic step(input string tag, input logic [31:0] w, input logic [31:0] ipc);
    logic        exp_we;
    logic [31:0] exp_val;
    rom_data = w;
    pc       = ipc;
    #1;
    check({tag, ".rom_addr"}, rom_addr, ipc);
    @(posedge clk);
    @(negedge clk);
    ref_exec(w, ipc, exp_we, exp_val);
    check({tag, ".inst"}, inst, w);
    check({tag, ".addr1"}, 32'(regs_addr1), 32'(w[19:15]));
    check({tag, ".addr2"}, 32'(regs_addr2), 32'(w[24:20]));
    check({tag, ".waddr"}, 32'(regs_write_addr), 32'(w[11:7]));
    check({tag, ".we"}, 32'(regs_write_en), 32'(exp_we));
    check({tag, ".out"}, regs_out, exp_val);
    if (exp_we) mregs[w[11:7]] = exp_val;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  f7;
    int          sel;
    sel = int'($urandom_range(0, 9));
    w   = $urandom;
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = w[31:25];
    endcase
    if (sel < 4)      w = {f7, w[24:7], 7'h33};
    else if (sel < 6) w = {w[31:7], 7'h13};
    else if (sel < 8) w = {f7, w[24:7], 7'h13};
    else if (sel < 9) w = {w[31:7], ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17};
    return w;
  endfunction

  initial begin
    rst      = 1'b1;
    pc       = 32'd0;
    rom_data = 32'd0;
    @(posedge clk);
    @(negedge clk);
    check("rst.inst", inst, 32'h0000_0013);
    check("rst.we", 32'(regs_write_en), 32'd0);
    check("rst.out", regs_out, 32'd0);
    for (int i = 0; i < 32; i++) mregs[i] = 32'(i);
    rst = 1'b0;

    step("add", 32'h0020_81B3, 32'd0);
    check("add.val", regs_out, 32'd3);
    step("sub", 32'h4011_0233, 32'd4);
    check("sub.val", regs_out, 32'd1);
    step("addi", 32'hFFF0_0293, 32'd8);
    check("addi.val", regs_out, 32'hFFFF_FFFF);
    step("srai", 32'h4010_D313, 32'd12);
    check("srai.val", regs_out, 32'd0);
    step("illegal", 32'h0000_0000, 32'd16);
    check("illegal.we", 32'(regs_write_en), 32'd0);
    step("add_x0", 32'h0020_8033, 32'd20);
    check("add_x0.we", 32'(regs_write_en), 32'd0);
    step("auipc", 32'h1234_5397, 32'd8);
`ifdef RUA_UPPER_IMM_EN
    check("auipc.val", regs_out, 32'h1234_5008);
`else
    check("auipc.we", 32'(regs_write_en), 32'd0);
`endif

    for (int n = 0; n < 300; n++) begin
      step("rand", rand_inst(), $urandom & 32'hFFFF_FFFC);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
